// File: rtl/io_stall_controller_if.sv
// CPU-side bus between the instruction path and the IO stall controller.
// Valid/ready: io_read with a matching addr is a request; advance=1 is ready, and the instruction retires in that cycle.
interface io_stall_controller_if;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic        advance;
  logic        sw_latch;
  logic        busy;

  modport master (
    output io_read,
    output io_write,
    output addr,
    input  advance,
    input  sw_latch,
    input  busy
  );

  modport slave (
    input  io_read,
    input  io_write,
    input  addr,
    output advance,
    output sw_latch,
    output busy
  );
endinterface

// File: rtl/io_stall_controller.sv
// Stalls the CPU on a switch read until a debounced button press is seen.
// It then pulses sw_latch and waits for the button release.
module io_stall_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter logic [31:0] SW_ADDR         = 32'hFFFF_FC70
) (
  input  logic                  clk,
  input  logic                  rst,
  io_stall_controller_if.slave  bus,
  input  logic                  enter,
  output logic [1:0]            state,
  output logic [7:0]            press_count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          db;
  logic          db_q;
  logic [CW-1:0] db_cnt;
  logic          rise;
  logic          sw_rd;
  state_t        state_q;
  state_t        state_d;
  logic          advance_c;
  logic          latch_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= enter;
      sync_q2 <= sync_q1;
    end
  end

  // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      db_q <= db;
      if (sync_q2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        db     <= ~db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign rise  = db & ~db_q;
  assign sw_rd = bus.io_read && (bus.addr == SW_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      press_count <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == CAPTURE) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    advance_c = 1'b1;
    latch_c   = 1'b0;
    case (state_q)
      IDLE: begin
        advance_c = ~sw_rd;
        if (sw_rd) begin
          state_d = db ? WAIT_RELEASE : WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        advance_c = 1'b0;
        if (!sw_rd) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        latch_c = 1'b1;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        advance_c = ~sw_rd;
        if (!db) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign bus.advance  = rst & advance_c;
  assign bus.busy     = rst & ~advance_c;
  assign bus.sw_latch = rst & latch_c;
  assign state        = state_q;

endmodule

// File: tb/tb_io_stall_controller.sv
// Directed bench for io_stall_controller with DEBOUNCE_CYCLES=4.
// Edge numbering in the press tests follows the cycle where enter is raised.
module tb_io_stall_controller;

  localparam logic [31:0] SW   = 32'hFFFF_FC70;
  localparam logic [31:0] NOSW = 32'hFFFF_FC60;

  logic       clk;
  logic       rst;
  logic       enter;
  logic [1:0] state;
  logic [7:0] press_count;

  int vectors     = 0;
  int miscompares = 0;
  int latch_cnt   = 0;
  int timeouts    = 0;
  int base;

  io_stall_controller_if bus ();

  io_stall_controller #(
    .DEBOUNCE_CYCLES(4),
    .SW_ADDR        (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .enter      (enter),
    .state      (state),
    .press_count(press_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (bus.sw_latch) latch_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (state == s) hit = 1'b1;
    end
  endtask

  task automatic do_capture();
    logic hit;
    bus.io_read = 1'b1;
    bus.addr    = SW;
    tick();
    enter = 1'b1;
    wait_state(2'd2, 20, hit);
    if (!hit) timeouts++;
    tick();
    bus.io_read = 1'b0;
    enter       = 1'b0;
    wait_state(2'd0, 20, hit);
    if (!hit) timeouts++;
  endtask

  initial begin
    logic hit;
    rst         = 1'b0;
    enter       = 1'b1;
    bus.io_read  = 1'b1;
    bus.io_write = 1'b0;
    bus.addr     = SW;

    // 1: reset held with enter and sw_rd active
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_advance", bus.advance, 1'b0);
      check("rst_latch", bus.sw_latch, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_state", state, 2'd0);
      check("rst_count", press_count, 8'd0);
    end
    rst = 1'b1;
    #1;
    check("post_rst_advance", bus.advance, 1'b0);
    check("post_rst_busy", bus.busy, 1'b1);
    tick();
    check("post_rst_state", state, 2'd1);
    bus.io_read = 1'b0;
    #1;
    check("wp_advance", bus.advance, 1'b0);
    tick();
    check("drop_to_idle", state, 2'd0);
    enter = 1'b0;
    ticks(14);
    check("drop_no_count", press_count, 8'd0);
    check("drop_no_latch", latch_cnt, 0);

    // 2: clean press
    bus.io_read = 1'b1;
    #1;
    check("p2_same_cycle_advance", bus.advance, 1'b0);
    check("p2_same_cycle_busy", bus.busy, 1'b1);
    tick();
    check("p2_wait_press", state, 2'd1);
    enter = 1'b1;
    base  = latch_cnt;
    ticks(6);
    check("p2_e6_state", state, 2'd1);
    check("p2_e6_latch", bus.sw_latch, 1'b0);
    tick();
    check("p2_e7_state", state, 2'd2);
    check("p2_e7_latch", bus.sw_latch, 1'b1);
    check("p2_e7_advance", bus.advance, 1'b1);
    check("p2_e7_busy", bus.busy, 1'b0);
    tick();
    check("p2_e8_state", state, 2'd3);
    check("p2_e8_latch", bus.sw_latch, 1'b0);
    check("p2_count", press_count, 8'd1);
    bus.io_read = 1'b0;
    #1;
    check("p2_wr_advance", bus.advance, 1'b1);
    enter = 1'b0;
    wait_state(2'd0, 20, hit);
    check("p2_release_idle", hit, 1'b1);
    check("p2_one_latch", latch_cnt - base, 1);

    // 3: bounce restarts the debounce count
    bus.io_read = 1'b1;
    tick();
    enter = 1'b1;
    base  = latch_cnt;
    ticks(3);
    enter = 1'b0;
    tick();
    enter = 1'b1;
    ticks(3);
    check("p3_e7_no_capture", state, 2'd1);
    ticks(3);
    check("p3_e10_state", state, 2'd1);
    tick();
    check("p3_e11_state", state, 2'd2);
    check("p3_e11_latch", bus.sw_latch, 1'b1);
    tick();
    bus.io_read = 1'b0;
    check("p3_count", press_count, 8'd2);
    check("p3_one_latch", latch_cnt - base, 1);

    // 4: held button across a second read
    tick();
    bus.io_read = 1'b1;
    #1;
    check("p4_stall_advance", bus.advance, 1'b0);
    ticks(5);
    check("p4_held_state", state, 2'd3);
    check("p4_held_busy", bus.busy, 1'b1);
    check("p4_no_latch", latch_cnt - base, 1);
    enter = 1'b0;
    wait_state(2'd0, 20, hit);
    check("p4_release_idle", hit, 1'b1);
    tick();
    check("p4_rearm", state, 2'd1);
    enter = 1'b1;
    wait_state(2'd2, 20, hit);
    check("p4_capture", hit, 1'b1);
    tick();
    bus.io_read = 1'b0;
    check("p4_count", press_count, 8'd3);
    check("p4_latches", latch_cnt - base, 2);
    enter = 1'b0;
    wait_state(2'd0, 20, hit);
    check("p4_idle", hit, 1'b1);
    ticks(8);

    // 5: non-matching address and io_write
    bus.io_read = 1'b1;
    bus.addr    = NOSW;
    #1;
    check("p5_addr_advance", bus.advance, 1'b1);
    check("p5_addr_busy", bus.busy, 1'b0);
    tick();
    check("p5_addr_state", state, 2'd0);
    bus.io_read  = 1'b0;
    bus.io_write = 1'b1;
    bus.addr     = SW;
    #1;
    check("p5_write_advance", bus.advance, 1'b1);
    tick();
    check("p5_write_state", state, 2'd0);
    bus.io_read = 1'b1;
    bus.addr    = NOSW;
    tick();
    check("p5_both_state", state, 2'd0);
    bus.io_read  = 1'b0;
    bus.io_write = 1'b0;

    // 6: reset while db is rising in WAIT_PRESS
    bus.io_read = 1'b1;
    bus.addr    = SW;
    tick();
    enter = 1'b1;
    base  = latch_cnt;
    ticks(6);
    check("p6_pre_state", state, 2'd1);
    #2;
    rst = 1'b0;
    #1;
    check("p6_state", state, 2'd0);
    check("p6_latch", bus.sw_latch, 1'b0);
    check("p6_count", press_count, 8'd0);
    check("p6_advance", bus.advance, 1'b0);
    ticks(2);
    check("p6_no_latch", latch_cnt - base, 0);
    bus.io_read = 1'b0;
    enter       = 1'b0;
    rst         = 1'b1;
    ticks(3);
    check("p6_after_state", state, 2'd0);

    // wrap of press_count
    base = latch_cnt;
    for (int i = 0; i < 255; i++) do_capture();
    check("wrap_255", press_count, 8'd255);
    do_capture();
    check("wrap_0", press_count, 8'd0);
    check("wrap_latches", latch_cnt - base, 256);
    check("wrap_timeouts", timeouts, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
